coef_unpacker: RTL and testbench
================================

COEF_UNPACKER -- requirements
Module: coef_unpacker

Interface
REQ-001 The module SHALL have parameter DAT_WIDTH, default 32, meaning the FIFO read word width; only 32 is supported.
REQ-002 The module SHALL have parameter COEF_WIDTH, default 12, meaning the packed coefficient width.
REQ-003 The module SHALL have parameter N_COEF, default 256, meaning coefficients per frame.
REQ-004 The module SHALL have parameter Q, default 3329, meaning the modulus used for range reduction.
REQ-005 Port clk, input, 1 bit: single clock; all logic SHALL be on its rising edge.
REQ-006 Port sclr, input, 1 bit: synchronous active-high reset.
REQ-007 Port start, input, 1 bit: one-cycle pulse that begins a frame.
REQ-008 Port rd_dat, input, DAT_WIDTH bits: FIFO read data, valid the cycle after an accepted rd_req.
REQ-009 Port rd_empty, input, 1 bit: FIFO empty.
REQ-010 Port rd_req, output, 1 bit: FIFO read request.
REQ-011 Port coef, output, COEF_WIDTH bits: reduced coefficient.
REQ-012 Port coef_idx, output, 8 bits: coefficient index within the frame, 0..255.
REQ-013 Port coef_valid, output, 1 bit: coef/coef_idx/coef_last are valid.
REQ-014 Port coef_ready, input, 1 bit: downstream accepts on coef_valid & coef_ready.
REQ-015 Port coef_last, output, 1 bit: high with coef_idx = 255.
REQ-016 Port busy, output, 1 bit: frame in progress.
REQ-017 Port done, output, 1 bit: one-cycle pulse after the last coefficient is accepted.
REQ-018 Port range_err, output, 1 bit: sticky; set when any raw coefficient in the frame is >= Q.

Function
REQ-019 States SHALL be IDLE, RUN and DONE: IDLE->RUN on start; RUN->DONE when coefficient 255 is accepted; DONE->IDLE after one cycle with done=1.
REQ-020 start outside IDLE SHALL be ignored; start in IDLE SHALL clear range_err, the word counter, the coefficient counter and the bit buffer.
REQ-021 The bit buffer SHALL be 56 bits with a fill count of 0..55; each returned word is appended above the current valid bits (little-endian bit order: word bit 0 follows the last valid bit).
REQ-022 rd_req SHALL be 1 only when the state is RUN, rd_empty=0, no read is in flight, words_read < 96, and fill count < 24.
REQ-023 A read SHALL be in flight for exactly the one cycle after rd_req=1; rd_dat SHALL be captured at the end of that cycle.
REQ-024 When fill count >= 12 and the output register is empty or is being accepted this cycle, buffer bits [11:0] SHALL load the output register, and the buffer SHALL shift right by 12 in the same cycle as any append.
REQ-025 Reduction: raw >= Q SHALL output raw-Q and set range_err; otherwise the output SHALL be raw; output width SHALL stay COEF_WIDTH.
REQ-026 coef/coef_idx/coef_last SHALL be held stable while coef_valid=1 and coef_ready=0.
REQ-027 Latency: the first coef_valid SHALL occur no later than 2 cycles after the first rd_dat capture, given rd_empty=0.
REQ-028 Throughput: with rd_empty=0 and coef_ready=1, the module SHALL sustain 8 coefficients per 3 words, without gaps in excess of those implied by the one-outstanding-read rule.
REQ-029 96 words SHALL yield exactly 256 coefficients; the fill count SHALL be 0 at DONE; no read SHALL be issued after word 96.
REQ-030 rd_empty asserting mid-frame SHALL stall reads only; buffered coefficients SHALL continue to drain.

Reset
REQ-031 sclr SHALL take precedence over all other inputs; it SHALL drive the state to IDLE and the following to 0: rd_req, coef_valid, coef, coef_idx, coef_last, busy, done, range_err, fill count and the counters.
REQ-032 sclr mid-frame SHALL abort the frame and discard an in-flight word; no done pulse SHALL be produced.

Structure
REQ-033 Q, N_COEF, COEF_WIDTH and the state encoding SHALL live in the shared Kyber package.
REQ-034 The reduction SHALL be a sub-module, coef_reduce (combinational compare-subtract); all other logic SHALL be flat.

Verification
REQ-035 Words 0x00002001, 0x00000000, 0x00000000 then zeros, coef_ready=1 -> coef 1, 2, then 0, with idx 0, 1, 2; range_err=0.
REQ-036 Word 0 = 0x00000FFF -> coef0=766, range_err=1, range_err held until the next start.
REQ-037 96 words with FIFO never empty, coef_ready=1 -> exactly 256 valids, coef_last on idx 255, done one cycle later, rd_req count = 96.
REQ-038 coef_ready=0 for 20 cycles at idx 10 -> outputs frozen, rd_req=0 once fill count >= 24; on resume, idx 10 is delivered once, with no loss or duplication.
REQ-039 rd_empty=1 for 15 cycles after word 40 -> no rd_req while empty; the frame completes with correct data.
REQ-040 sclr at idx 100, then start -> all outputs 0 the cycle after sclr; the new frame begins at idx 0 with an empty buffer.

Source files
------------

// File: rtl/coef_unpacker_pkg.sv
// -----------------------------------------------------------------------------
// coef_unpacker_pkg
//
// Shared Kyber constants used by the coefficient unpacking path.
//
// Contents:
//    KYBER_Q           modulus used for the compare-subtract reduction
//    KYBER_N           coefficients per polynomial frame
//    KYBER_COEF_WIDTH  packed coefficient width in bits
//    BUF_WIDTH         width of the unpacker bit buffer
//    FILL_WIDTH        width of the bit buffer fill counter (0..55)
//    ST_*              unpacker FSM state encoding
//    words_per_frame   number of FIFO words that carry one full frame
// -----------------------------------------------------------------------------
package coef_unpacker_pkg;

   localparam int KYBER_Q          = 3329;
   localparam int KYBER_N          = 256;
   localparam int KYBER_COEF_WIDTH = 12;

   // 56 bits is enough to hold up to 23 leftover bits plus one 32-bit word,
   // which is the worst case given reads are only issued below 24 bits.
   localparam int BUF_WIDTH  = 56;
   localparam int FILL_WIDTH = 6;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   function automatic int words_per_frame(input int n_coef,
                                          input int coef_width,
                                          input int dat_width);
      return (n_coef * coef_width) / dat_width;
   endfunction

endpackage

// File: rtl/coef_reduce.sv
// -----------------------------------------------------------------------------
// coef_reduce
//
// Single-step range reduction of a packed coefficient: values at or above Q
// have Q subtracted once. A 12-bit raw value is at most 4095, so one
// subtraction always lands inside [0, Q).
//
// Ports:
//    raw           raw packed coefficient taken from the bit buffer
//    reduced       raw, or raw - Q when raw >= Q
//    out_of_range  high when raw >= Q
// -----------------------------------------------------------------------------
module coef_reduce
   import coef_unpacker_pkg::*;
#(
   parameter int COEF_WIDTH = KYBER_COEF_WIDTH,
   parameter int Q          = KYBER_Q
) (
   input  logic [COEF_WIDTH-1:0] raw,
   output logic [COEF_WIDTH-1:0] reduced,
   output logic                  out_of_range
);

   localparam logic [COEF_WIDTH-1:0] Q_W = COEF_WIDTH'(Q);

   // Compare against Q and subtract it once; output keeps the input width.
   always_comb begin
      out_of_range = (raw >= Q_W);
      reduced      = raw;
      if (out_of_range) begin
         reduced = raw - Q_W;
      end
   end

endmodule

// File: rtl/coef_unpacker.sv
// -----------------------------------------------------------------------------
// coef_unpacker
//
// Pulls 32-bit words from a FIFO, splits the little-endian bit stream into
// 12-bit coefficients, range-reduces each one against Q and presents them on
// a valid/ready output. One frame is 256 coefficients carried by 96 words.
//
// Ports:
//    clk         single clock, all logic on the rising edge
//    sclr        synchronous active-high reset, overrides everything
//    start       one-cycle pulse that begins a frame (ignored unless idle)
//    rd_dat      FIFO read data, valid the cycle after an accepted rd_req
//    rd_empty    FIFO empty flag
//    rd_req      FIFO read request
//    coef        reduced coefficient
//    coef_idx    coefficient index within the frame
//    coef_valid  coef/coef_idx/coef_last are valid
//    coef_ready  downstream accepts on coef_valid & coef_ready
//    coef_last   high with the final coefficient of the frame
//    busy        frame in progress
//    done        one-cycle pulse after the last coefficient is accepted
//    range_err   sticky flag: some raw coefficient in the frame was >= Q
//
// DAT_WIDTH other than 32 is not supported.
// -----------------------------------------------------------------------------
module coef_unpacker
   import coef_unpacker_pkg::*;
#(
   parameter int DAT_WIDTH  = 32,
   parameter int COEF_WIDTH = KYBER_COEF_WIDTH,
   parameter int N_COEF     = KYBER_N,
   parameter int Q          = KYBER_Q
) (
   input  logic                  clk,
   input  logic                  sclr,
   input  logic                  start,
   input  logic [DAT_WIDTH-1:0]  rd_dat,
   input  logic                  rd_empty,
   output logic                  rd_req,
   output logic [COEF_WIDTH-1:0] coef,
   output logic [7:0]            coef_idx,
   output logic                  coef_valid,
   input  logic                  coef_ready,
   output logic                  coef_last,
   output logic                  busy,
   output logic                  done,
   output logic                  range_err
);

   localparam int WORDS  = words_per_frame(N_COEF, COEF_WIDTH, DAT_WIDTH);
   localparam int WCNT_W = $clog2(WORDS + 1);
   localparam int CCNT_W = $clog2(N_COEF + 1);

   localparam logic [WCNT_W-1:0]     WORDS_W       = WCNT_W'(WORDS);
   localparam logic [CCNT_W-1:0]     N_COEF_W      = CCNT_W'(N_COEF);
   localparam logic [CCNT_W-1:0]     LAST_IDX_W    = CCNT_W'(N_COEF - 1);
   localparam logic [FILL_WIDTH-1:0] FILL_POP      = FILL_WIDTH'(COEF_WIDTH);
   localparam logic [FILL_WIDTH-1:0] FILL_WORD     = FILL_WIDTH'(DAT_WIDTH);
   localparam logic [FILL_WIDTH-1:0] FILL_RD_LIMIT = FILL_WIDTH'(BUF_WIDTH - DAT_WIDTH);

   logic [1:0]            state;
   logic [BUF_WIDTH-1:0]  bit_buf;
   logic [FILL_WIDTH-1:0] fill;
   logic [WCNT_W-1:0]     words_read;
   logic [CCNT_W-1:0]     coef_cnt;
   logic                  in_flight;

   logic                  start_frame;
   logic                  accept;
   logic                  pop;
   logic [BUF_WIDTH-1:0]  buf_shift;
   logic [BUF_WIDTH-1:0]  buf_next;
   logic [FILL_WIDTH-1:0] fill_shift;
   logic [FILL_WIDTH-1:0] fill_next;

   logic [COEF_WIDTH-1:0] raw_coef;
   logic [COEF_WIDTH-1:0] red_coef;
   logic                  raw_oor;

   assign start_frame = (state == ST_IDLE) && start;
   assign accept      = coef_valid && coef_ready;
   assign busy        = (state == ST_RUN);

   // A coefficient leaves the buffer whenever 12 bits are available and the
   // output register is free or being emptied this cycle, so a steady
   // coef_ready=1 gives one coefficient per cycle out of the buffer.
   assign pop = (state == ST_RUN) && (fill >= FILL_POP) &&
                (!coef_valid || coef_ready) && (coef_cnt < N_COEF_W);

   // Only one read may be outstanding, and a read is only issued while the
   // buffer can still take a full word after any pops in the landing cycle.
   assign rd_req = !sclr && (state == ST_RUN) && !rd_empty && !in_flight &&
                   (words_read < WORDS_W) && (fill < FILL_RD_LIMIT);

   assign raw_coef = bit_buf[COEF_WIDTH-1:0];

   coef_reduce #(
      .COEF_WIDTH (COEF_WIDTH),
      .Q          (Q)
   ) u_reduce (
      .raw          (raw_coef),
      .reduced      (red_coef),
      .out_of_range (raw_oor)
   );

   // Next buffer contents: drop the popped coefficient first, then place the
   // landing word directly above whatever bits remain, so pop and append can
   // happen in the same cycle without losing ordering.
   always_comb begin
      buf_shift  = bit_buf;
      fill_shift = fill;
      if (pop) begin
         buf_shift  = bit_buf >> COEF_WIDTH;
         fill_shift = fill - FILL_POP;
      end
      buf_next  = buf_shift;
      fill_next = fill_shift;
      if (in_flight) begin
         buf_next  = buf_shift | (BUF_WIDTH'(rd_dat) << fill_shift);
         fill_next = fill_shift + FILL_WORD;
      end
   end

   // Frame sequencing: IDLE waits for start, RUN lasts until the final
   // coefficient is accepted, DONE is a single cycle that raises done.
   // The in-flight flag marks the cycle in which rd_dat must be captured.
   always_ff @(posedge clk) begin
      if (sclr) begin
         state      <= ST_IDLE;
         done       <= 1'b0;
         in_flight  <= 1'b0;
         words_read <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               in_flight <= 1'b0;
               if (start) begin
                  state      <= ST_RUN;
                  words_read <= '0;
               end
            end
            ST_RUN: begin
               in_flight <= rd_req;
               if (rd_req) begin
                  words_read <= words_read + 1'b1;
               end
               if (accept && coef_last) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end
            end
            ST_DONE: begin
               in_flight <= 1'b0;
               state     <= ST_IDLE;
            end
            default: begin
               in_flight <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

   // Bit buffer and its fill count. Cleared at the start of each frame so a
   // previous aborted frame can never leak bits into the next one.
   always_ff @(posedge clk) begin
      if (sclr) begin
         bit_buf <= '0;
         fill    <= '0;
      end else if (start_frame) begin
         bit_buf <= '0;
         fill    <= '0;
      end else if (state == ST_RUN) begin
         bit_buf <= buf_next;
         fill    <= fill_next;
      end
   end

   // Output register. It is only reloaded by a pop, and a pop is only allowed
   // when the register is free or being accepted, so the presented value stays
   // frozen for as long as the consumer holds coef_ready low.
   always_ff @(posedge clk) begin
      if (sclr) begin
         coef       <= '0;
         coef_idx   <= '0;
         coef_last  <= 1'b0;
         coef_valid <= 1'b0;
         coef_cnt   <= '0;
         range_err  <= 1'b0;
      end else if (start_frame) begin
         coef_valid <= 1'b0;
         coef_cnt   <= '0;
         range_err  <= 1'b0;
      end else if (pop) begin
         coef       <= red_coef;
         coef_idx   <= coef_cnt[7:0];
         coef_last  <= (coef_cnt == LAST_IDX_W);
         coef_valid <= 1'b1;
         coef_cnt   <= coef_cnt + 1'b1;
         if (raw_oor) begin
            range_err <= 1'b1;
         end
      end else if (accept) begin
         coef_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_coef_unpacker.sv
// -----------------------------------------------------------------------------
// tb_coef_unpacker
//
// Self-checking bench for coef_unpacker. A FIFO model feeds words, a bit-level
// reference model turns each frame into the expected coefficient stream kept
// in a scoreboard queue, and a monitor compares every presented coefficient
// against the head of that queue.
// -----------------------------------------------------------------------------
module tb_coef_unpacker;

   localparam int TB_Q     = 3329;
   localparam int TB_WORDS = 96;
   localparam int TB_NCOEF = 256;

   logic        clk = 1'b0;
   logic        sclr = 1'b1;
   logic        start = 1'b0;
   logic [31:0] rd_dat = '0;
   logic        rd_empty = 1'b1;
   logic        rd_req;
   logic [11:0] coef;
   logic [7:0]  coef_idx;
   logic        coef_valid;
   logic        coef_ready = 1'b1;
   logic        coef_last;
   logic        busy;
   logic        done;
   logic        range_err;

   typedef struct packed {
      logic [11:0] coef;
      logic [7:0]  idx;
      logic        last;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] fifo_q[$];
   logic [31:0] frame_words [TB_WORDS];

   int assert_count = 0;
   int fail_count   = 0;

   int cyc = 0;
   int req_cnt = 0;
   int valid_cnt = 0;
   int first_req_cyc = 0;
   int first_valid_cyc = 0;
   bit first_valid_seen = 0;
   bit done_pending = 0;
   bit frame_done = 0;
   int stall_at = 0;
   int stall_left = 0;
   bit stall_seen = 0;
   int hold_idx = -1;
   bit hold_active = 0;
   bit hold_seen = 0;
   int hold_left = 0;
   int hold_late_req = 0;
   int watch_idx = -1;
   bit watch_hit = 0;

   coef_unpacker #(
      .DAT_WIDTH  (32),
      .COEF_WIDTH (12),
      .N_COEF     (256),
      .Q          (3329)
   ) dut (
      .clk        (clk),
      .sclr       (sclr),
      .start      (start),
      .rd_dat     (rd_dat),
      .rd_empty   (rd_empty),
      .rd_req     (rd_req),
      .coef       (coef),
      .coef_idx   (coef_idx),
      .coef_valid (coef_valid),
      .coef_ready (coef_ready),
      .coef_last  (coef_last),
      .busy       (busy),
      .done       (done),
      .range_err  (range_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      assert_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                  tag, actual, expected, $time);
      end
   endtask

   // Bit-level reference: coefficient i is stream bits [12i+11 : 12i], with
   // stream bit p living in word p/32 at position p%32.
   task automatic buildExpected(output logic err);
      int          pos;
      logic [11:0] raw;
      exp_t        e;
      err = 1'b0;
      for (int i = 0; i < TB_NCOEF; i++) begin
         for (int b = 0; b < 12; b++) begin
            pos    = 12 * i + b;
            raw[b] = frame_words[pos / 32][pos % 32];
         end
         e.idx  = 8'(i);
         e.last = (i == TB_NCOEF - 1);
         if (int'(raw) >= TB_Q) begin
            e.coef = 12'(int'(raw) - TB_Q);
            err    = 1'b1;
         end else begin
            e.coef = raw;
         end
         exp_q.push_back(e);
      end
   endtask

   // kind 0: 0x00002001 then zeros; kind 1: 0x00000FFF then random;
   // kind 2: all random.
   task automatic applyStimulus(input int kind, input int stall_after,
                                input int hold_at, input int watch_at,
                                output logic exp_err);
      for (int w = 0; w < TB_WORDS; w++) begin
         case (kind)
            0:       frame_words[w] = (w == 0) ? 32'h0000_2001 : 32'h0;
            1:       frame_words[w] = (w == 0) ? 32'h0000_0FFF : $urandom;
            default: frame_words[w] = $urandom;
         endcase
         fifo_q.push_back(frame_words[w]);
      end
      buildExpected(exp_err);
      req_cnt          = 0;
      valid_cnt        = 0;
      first_valid_seen = 0;
      done_pending     = 0;
      frame_done       = 0;
      stall_at         = stall_after;
      stall_left       = 0;
      stall_seen       = 0;
      hold_idx         = hold_at;
      hold_active      = 0;
      hold_seen        = 0;
      hold_late_req    = 0;
      watch_idx        = watch_at;
      watch_hit        = 0;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("busy_after_start", busy, 1);
      checkOutput("range_err_cleared_by_start", range_err, 0);
      checkOutput("no_valid_at_start", coef_valid, 0);
   endtask

   task automatic waitFrame(input string name, input logic exp_err);
      int budget;
      budget = 0;
      while (!frame_done && budget < 3000) begin
         @(posedge clk); #1;
         budget++;
      end
      checkOutput({name, "_completed"}, frame_done, 1);
      checkOutput({name, "_valid_count"}, valid_cnt, TB_NCOEF);
      checkOutput({name, "_rd_req_count"}, req_cnt, TB_WORDS);
      checkOutput({name, "_scoreboard_left"}, exp_q.size(), 0);
      checkOutput({name, "_range_err"}, range_err, exp_err);
      repeat (2) begin
         @(posedge clk); #1;
      end
      checkOutput({name, "_busy_after_done"}, busy, 0);
      checkOutput({name, "_rd_req_after_done"}, req_cnt, TB_WORDS);
      exp_q.delete();
      fifo_q.delete();
   endtask

   task automatic checkIdleOutputs(input string name);
      checkOutput({name, "_rd_req"}, rd_req, 0);
      checkOutput({name, "_coef_valid"}, coef_valid, 0);
      checkOutput({name, "_coef"}, coef, 0);
      checkOutput({name, "_coef_idx"}, coef_idx, 0);
      checkOutput({name, "_coef_last"}, coef_last, 0);
      checkOutput({name, "_busy"}, busy, 0);
      checkOutput({name, "_done"}, done, 0);
      checkOutput({name, "_range_err"}, range_err, 0);
   endtask

   // FIFO model, consumer model and monitor in one process so that input
   // updates and output sampling happen in a fixed order each cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (hold_idx >= 0 && !hold_seen && coef_valid && int'(coef_idx) == hold_idx) begin
            hold_active = 1;
            hold_seen   = 1;
            hold_left   = 20;
         end
         if (hold_active) begin
            if (hold_left > 0) begin
               coef_ready = 1'b0;
               hold_left--;
            end else begin
               coef_ready  = 1'b1;
               hold_active = 0;
            end
         end
         if (stall_left > 0) begin
            rd_empty = 1'b1;
            stall_left--;
         end else begin
            rd_empty = (fifo_q.size() == 0);
         end
         #1;
         if (rd_req) begin
            checkOutput("rd_req_while_empty", rd_empty, 0);
            if (fifo_q.size() > 0) rd_dat = fifo_q.pop_front();
            req_cnt++;
            if (req_cnt == 1) first_req_cyc = cyc;
            if (stall_at != 0 && req_cnt == stall_at) begin
               stall_left = 15;
               stall_seen = 1;
            end
            if (hold_active && hold_left < 10) hold_late_req++;
         end
         if (done_pending) begin
            checkOutput("done_pulse", done, 1);
            done_pending = 0;
            frame_done   = 1;
         end else if (done) begin
            checkOutput("done_spurious", done, 0);
         end
         if (coef_valid) begin
            if (!first_valid_seen) begin
               first_valid_seen = 1;
               first_valid_cyc  = cyc;
            end
            if (int'(coef_idx) == watch_idx) watch_hit = 1;
            if (exp_q.size() == 0) begin
               checkOutput("coef_unexpected", coef_valid, 0);
            end else begin
               e = exp_q[0];
               checkOutput("coef", coef, e.coef);
               checkOutput("coef_idx", coef_idx, e.idx);
               checkOutput("coef_last", coef_last, e.last);
               if (coef_ready) begin
                  void'(exp_q.pop_front());
                  valid_cnt++;
                  if (e.last) done_pending = 1;
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic exp_err;
      int   budget;

      repeat (3) @(posedge clk);
      #1;
      checkIdleOutputs("reset");
      sclr = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      $display("[TB] frame 1: 0x00002001 then zeros");
      applyStimulus(0, 0, -1, -1, exp_err);
      waitFrame("f1", exp_err);
      checkOutput("f1_first_valid_within_2_of_capture",
                  32'(first_valid_seen && (first_valid_cyc - first_req_cyc <= 3)), 1);

      $display("[TB] frame 2: first word 0x00000FFF");
      applyStimulus(1, 0, -1, -1, exp_err);
      checkOutput("f2_model_range_err", exp_err, 1);
      waitFrame("f2", 1'b1);
      repeat (5) @(posedge clk);
      #1;
      checkOutput("f2_range_err_sticky", range_err, 1);

      $display("[TB] frame 3: FIFO empty for 15 cycles after word 40");
      applyStimulus(2, 40, -1, -1, exp_err);
      waitFrame("f3", exp_err);
      checkOutput("f3_stall_applied", stall_seen, 1);

      $display("[TB] frame 4: coef_ready low for 20 cycles at idx 10");
      applyStimulus(2, 0, 10, -1, exp_err);
      waitFrame("f4", exp_err);
      checkOutput("f4_hold_applied", hold_seen, 1);
      checkOutput("f4_reads_while_buffer_full", hold_late_req, 0);

      $display("[TB] frame 5: sclr at idx 100");
      applyStimulus(2, 0, -1, 100, exp_err);
      budget = 0;
      while (!watch_hit && budget < 3000) begin
         @(posedge clk); #1;
         budget++;
      end
      checkOutput("f5_reached_idx_100", watch_hit, 1);
      sclr = 1'b1;
      @(posedge clk); #1;
      checkIdleOutputs("after_sclr");
      sclr = 1'b0;
      exp_q.delete();
      fifo_q.delete();
      done_pending = 0;
      watch_idx    = -1;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("no_done_after_abort", frame_done, 0);

      $display("[TB] frame 6: new frame after abort");
      applyStimulus(2, 0, -1, -1, exp_err);
      waitFrame("f6", exp_err);

      $display("End of test - %0d assertions evaluated, %0d failures",
               assert_count, fail_count);
      $finish;
   end

endmodule
